seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 8: digit positions on the scanned display.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive clocks a digit/pattern pair must hold before acceptance; legal range 2..255.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 an_n  input  NUM_DIGITS: active-low digit enable; exactly one bit low selects a digit.
REQ-006 seg_n  input  7: active-low segments; bit0=a through bit6=g.
REQ-007 out_valid  output  1: a complete frame is presented.
REQ-008 out_ready  input  1: consumer accepts the frame.
REQ-009 out_digits  output  4*NUM_DIGITS: BCD per position; nibble i = digit i.
REQ-010 out_blank  output  NUM_DIGITS: position showed all segments off.
REQ-011 out_err  output  NUM_DIGITS: position showed a non-decodable pattern.
REQ-012 out_overrun  output  1: at least one completed frame was dropped since the last transfer.

Function
REQ-013 The block SHALL register an_n and seg_n once (sample stage) before any comparison.
REQ-014 The decoder SHALL map seg_n 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000 to 0..9; 1111111 to nibble 0xF with blank=1; any other pattern to 0xE with err=1.
REQ-015 A sampled pair with an_n not one-hot-low SHALL be ignored and clear the stability counter.
REQ-016 The stability counter SHALL increment when the sampled pair equals the previous sampled pair, clear to 0 on any difference, and saturate at STABLE_CYCLES.
REQ-017 Acceptance SHALL occur exactly once per stable run, on the edge where the counter reaches STABLE_CYCLES-1, i.e. after the pair was presented for STABLE_CYCLES consecutive clocks (plus one sample-stage clock).
REQ-018 Acceptance SHALL write the decoded nibble/blank/err into working slot i and set seen[i]; re-acceptance of a seen position overwrites its slot.
REQ-019 FSM states COLLECT and PRESENT; COLLECT->PRESENT when an acceptance makes seen all-ones; PRESENT->COLLECT on out_valid&&out_ready with no simultaneous frame completion.
REQ-020 On frame completion the output registers SHALL load the working slots (including the accepting write) on that same edge, seen SHALL clear, and out_valid SHALL be 1 in the following cycle.
REQ-021 Collection SHALL continue in PRESENT; outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Frame completion while out_valid=1 and out_ready=0 SHALL drop the new frame (outputs unchanged) and set out_overrun.
REQ-023 Frame completion on the same edge as a transfer SHALL load the new frame, keep out_valid=1, and not set out_overrun.
REQ-024 out_overrun SHALL clear on each transfer unless REQ-022 sets it on that edge.

Reset
REQ-025 While rst_n=0: out_valid=0, out_digits=0, out_blank=0, out_err=0, out_overrun=0, FSM=COLLECT, seen=0, counter=0, sample registers an_n=all-ones, seg_n=all-ones.
REQ-026 Reset asserted mid-frame or mid-presentation SHALL discard all partial and presented data; first acceptance after release requires a full stable run.

Structure
REQ-027 Package seg7_pkg SHALL hold the ten segment constants, SEG_BLANK, nibble codes 0xE/0xF, and the FSM state enum.
REQ-028 Sub-module seg7_pattern_decode (combinational, pattern->nibble/blank/err) SHALL implement REQ-014.

Verification
REQ-029 Scan digits 0..7 showing 1,2,3,4,5,6,7,8, 6 clocks each, out_ready=1 -> one frame out_digits=0x87654321, out_blank=0, out_err=0.
REQ-030 Hold one pair for STABLE_CYCLES-1 clocks then change -> no acceptance; seen unchanged.
REQ-031 Digit 3 shows 1111111, digit 5 shows 0000001 -> out_blank=0x08, out_err=0x20, nibbles 0xF and 0xE.
REQ-032 out_ready=0, scan two full frames -> first frame held unchanged, out_overrun=1; assert out_ready -> transfer, out_overrun=0 next cycle.
REQ-033 an_n=11110011 (two low) for 10 clocks -> no acceptance; rst_n pulse low mid-frame -> all outputs 0, next frame needs all 8 positions.
REQ-034 Frame completion coincident with out_valid&&out_ready -> new data next cycle, out_valid stays 1, out_overrun=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Segment patterns are active-low, bit0 = segment a through bit6 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIB_ERR   = 4'hE;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Frame output channel: valid/ready handshake carrying one decoded display frame.
interface seg7_scan_capture_if #(
    parameter int unsigned NUM_DIGITS = 8
) ();

    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] out_digits;
    logic [NUM_DIGITS-1:0]   out_blank;
    logic [NUM_DIGITS-1:0]   out_err;
    logic                    out_overrun;

    modport master (
        output out_valid,
        output out_digits,
        output out_blank,
        output out_err,
        output out_overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digits,
        input  out_blank,
        input  out_err,
        input  out_overrun,
        output out_ready
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder: digits 0..9, blank (0xF) or error (0xE).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] nib_o,
    output logic       blank_o,
    output logic       err_o
);

    always_comb begin
        nib_o   = NIB_ERR;
        blank_o = 1'b0;
        err_o   = 1'b0;
        case (seg_n_i)
            SEG_0:     nib_o = 4'd0;
            SEG_1:     nib_o = 4'd1;
            SEG_2:     nib_o = 4'd2;
            SEG_3:     nib_o = 4'd3;
            SEG_4:     nib_o = 4'd4;
            SEG_5:     nib_o = 4'd5;
            SEG_6:     nib_o = 4'd6;
            SEG_7:     nib_o = 4'd7;
            SEG_8:     nib_o = 4'd8;
            SEG_9:     nib_o = 4'd9;
            SEG_BLANK: begin
                nib_o   = NIB_BLANK;
                blank_o = 1'b1;
            end
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a multiplexed 7-segment display, accepts each digit once it is stable,
// and presents complete frames on a valid/ready channel with overrun flagging.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] an_n,
    input  logic [6:0]            seg_n,
    seg7_scan_capture_if.master   out_if
);

    localparam logic [7:0] SAT_CNT = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS-1:0]   an_q, prev_an_q;
    logic [6:0]              seg_q, prev_seg_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] work_nib_q, work_nib_d;
    logic [NUM_DIGITS-1:0]   work_blank_q, work_blank_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] out_digits_q, out_digits_d;
    logic [NUM_DIGITS-1:0]   out_blank_q, out_blank_d;
    logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_DIGITS-1:0]   pick;
    logic                    onehot;
    logic                    same;
    logic                    accept;
    logic                    frame_done;
    logic                    load;
    logic [3:0]              dec_nib;
    logic                    dec_blank;
    logic                    dec_err;

    seg7_pattern_decode u_decode (
        .seg_n_i (seg_q),
        .nib_o   (dec_nib),
        .blank_o (dec_blank),
        .err_o   (dec_err)
    );

    // Stability tracking compares the sampled pair against the one sampled a clock earlier.
    always_comb begin
        pick   = ~an_q;
        onehot = ($countones(pick) == 1);
        same   = (an_q == prev_an_q) && (seg_q == prev_seg_q);
        accept = onehot && same && (cnt_q == ACC_CNT);

        cnt_d = cnt_q;
        if (!onehot || !same) begin
            cnt_d = '0;
        end else if (cnt_q < SAT_CNT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // The accepting write is folded into the _d slots so a completing frame loads it too.
    always_comb begin
        seen_d       = seen_q;
        work_nib_d   = work_nib_q;
        work_blank_d = work_blank_q;
        work_err_d   = work_err_q;
        if (accept) begin
            seen_d = seen_q | pick;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (pick[i]) begin
                    work_nib_d[i*4 +: 4] = dec_nib;
                    work_blank_d[i]      = dec_blank;
                    work_err_d[i]        = dec_err;
                end
            end
        end
        frame_done = accept && (&seen_d);
        if (frame_done) begin
            seen_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    state_d = PRESENT;
                    load    = 1'b1;
                end
            end
            PRESENT: begin
                if (out_if.out_ready) begin
                    overrun_d = 1'b0;
                    if (frame_done) begin
                        load = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (frame_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase

        out_digits_d = load ? work_nib_d   : out_digits_q;
        out_blank_d  = load ? work_blank_d : out_blank_q;
        out_err_d    = load ? work_err_d   : out_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= '1;
            seg_q        <= '1;
            prev_an_q    <= '1;
            prev_seg_q   <= '1;
            cnt_q        <= '0;
            seen_q       <= '0;
            work_nib_q   <= '0;
            work_blank_q <= '0;
            work_err_q   <= '0;
            state_q      <= COLLECT;
            out_digits_q <= '0;
            out_blank_q  <= '0;
            out_err_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            an_q         <= an_n;
            seg_q        <= seg_n;
            prev_an_q    <= an_q;
            prev_seg_q   <= seg_q;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            work_nib_q   <= work_nib_d;
            work_blank_q <= work_blank_d;
            work_err_q   <= work_err_d;
            state_q      <= state_d;
            out_digits_q <= out_digits_d;
            out_blank_q  <= out_blank_d;
            out_err_q    <= out_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_if.out_valid   = (state_q == PRESENT);
    assign out_if.out_digits  = out_digits_q;
    assign out_if.out_blank   = out_blank_q;
    assign out_if.out_err     = out_err_q;
    assign out_if.out_overrun = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans frames onto the display inputs and
// checks captured frames, handshake behaviour, overrun and reset against hand values.
module tb_seg7_scan_capture;

    localparam int unsigned ND = 8;
    localparam int unsigned SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] an_n;
    logic [6:0]    seg_n;

    int            total = 0;
    int            bad   = 0;
    int            xfer_cnt = 0;
    logic [31:0]   cap_digits = '0;
    logic [7:0]    cap_blank  = '0;
    logic [7:0]    cap_err    = '0;

    seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .an_n   (an_n),
        .seg_n  (seg_n),
        .out_if (bus)
    );

    always #5 clk = ~clk;

    // Inputs move just after rising edges, so valid&&ready here means a transfer at the next edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xfer_cnt   = xfer_cnt + 1;
            cap_digits = bus.out_digits;
            cap_blank  = bus.out_blank;
            cap_err    = bus.out_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic show(input int pos, input logic [6:0] seg, input int n);
        an_n  = ~(8'b1 << pos);
        seg_n = seg;
        step(n);
    endtask

    task automatic idle(input int n);
        an_n  = '1;
        seg_n = '1;
        step(n);
    endtask

    task automatic scan(input logic [31:0] vals, input logic [7:0] mask, input int n);
        for (int p = 0; p < 8; p++) begin
            if (mask[p]) show(p, seg_of(vals[p*4 +: 4]), n);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        an_n          = '1;
        seg_n         = '1;
        bus.out_ready = 1'b1;
        step(3);
        check("rst_valid",   32'(bus.out_valid),   32'h0);
        check("rst_digits",  bus.out_digits,       32'h0);
        check("rst_blank",   32'(bus.out_blank),   32'h0);
        check("rst_err",     32'(bus.out_err),     32'h0);
        check("rst_overrun", 32'(bus.out_overrun), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Basic frame, six clocks per digit, consumer always ready
        scan(32'h87654321, 8'hFF, 6);
        idle(2);
        check("f1_xfers",   32'(xfer_cnt),        32'd1);
        check("f1_digits",  cap_digits,           32'h87654321);
        check("f1_blank",   32'(cap_blank),       32'h0);
        check("f1_err",     32'(cap_err),         32'h0);
        check("f1_valid",   32'(bus.out_valid),   32'h0);
        check("f1_overrun", 32'(bus.out_overrun), 32'h0);

        // Digit 0 held one clock short of acceptance; the frame must stay incomplete
        show(0, seg_of(4'd9), SC - 1);
        scan(32'h65432109, 8'hFE, SC);
        idle(2);
        check("short_xfers", 32'(xfer_cnt),      32'd1);
        check("short_valid", 32'(bus.out_valid), 32'h0);
        show(0, seg_of(4'd9), SC);
        idle(2);
        check("f2_xfers",  32'(xfer_cnt), 32'd2);
        check("f2_digits", cap_digits,    32'h65432109);

        // Blank at position 3, undecodable pattern at position 5
        show(0, 7'h40, SC);
        show(1, 7'h79, SC);
        show(2, 7'h24, SC);
        show(3, 7'h7F, SC);
        show(4, 7'h19, SC);
        show(5, 7'h01, SC);
        show(6, 7'h02, SC);
        show(7, 7'h78, SC);
        idle(2);
        check("f3_xfers",  32'(xfer_cnt),  32'd3);
        check("f3_digits", cap_digits,     32'h76E4F210);
        check("f3_blank",  32'(cap_blank), 32'h08);
        check("f3_err",    32'(cap_err),   32'h20);

        // Back-pressure: second frame dropped, overrun raised, cleared by the transfer
        bus.out_ready = 1'b0;
        scan(32'h23456789, 8'hFF, SC);
        idle(2);
        check("bp_valid",   32'(bus.out_valid),   32'h1);
        check("bp_digits",  bus.out_digits,       32'h23456789);
        check("bp_overrun", 32'(bus.out_overrun), 32'h0);
        check("bp_xfers",   32'(xfer_cnt),        32'd3);
        scan(32'h00000000, 8'hFF, SC);
        idle(2);
        check("ovr_valid",   32'(bus.out_valid),   32'h1);
        check("ovr_digits",  bus.out_digits,       32'h23456789);
        check("ovr_overrun", 32'(bus.out_overrun), 32'h1);
        bus.out_ready = 1'b1;
        step(1);
        check("ovr_xfers",      32'(xfer_cnt),        32'd4);
        check("ovr_cap",        cap_digits,           32'h23456789);
        check("ovr_valid_done", 32'(bus.out_valid),   32'h0);
        check("ovr_cleared",    32'(bus.out_overrun), 32'h0);

        // Two digit enables low at once must never be accepted
        scan(32'h87654321, 8'hF3, SC);
        an_n  = 8'b11110011;
        seg_n = 7'h79;
        step(10);
        show(2, seg_of(4'd3), SC);
        idle(2);
        check("twolow_xfers", 32'(xfer_cnt),      32'd4);
        check("twolow_valid", 32'(bus.out_valid), 32'h0);
        show(3, seg_of(4'd4), SC);
        idle(2);
        check("f4_xfers",  32'(xfer_cnt), 32'd5);
        check("f4_digits", cap_digits,    32'h87654321);

        // Reset mid-presentation with overrun set and a partial frame in flight
        bus.out_ready = 1'b0;
        scan(32'h99999999, 8'hFF, SC);
        idle(2);
        check("pre_valid",  32'(bus.out_valid), 32'h1);
        check("pre_digits", bus.out_digits,     32'h99999999);
        scan(32'h00000000, 8'hFF, SC);
        idle(2);
        check("pre_overrun", 32'(bus.out_overrun), 32'h1);
        scan(32'h55555555, 8'h0F, SC);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid",   32'(bus.out_valid),   32'h0);
        check("mid_rst_digits",  bus.out_digits,       32'h0);
        check("mid_rst_blank",   32'(bus.out_blank),   32'h0);
        check("mid_rst_err",     32'(bus.out_err),     32'h0);
        check("mid_rst_overrun", 32'(bus.out_overrun), 32'h0);
        step(2);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        scan(32'h11112222, 8'hF0, SC);
        idle(2);
        check("post_rst_xfers", 32'(xfer_cnt),      32'd5);
        check("post_rst_valid", 32'(bus.out_valid), 32'h0);
        scan(32'h11112222, 8'h0F, SC);
        idle(2);
        check("f5_xfers",  32'(xfer_cnt), 32'd6);
        check("f5_digits", cap_digits,    32'h11112222);

        // Frame completion on the same edge as a transfer
        bus.out_ready = 1'b0;
        scan(32'h76543210, 8'hFF, SC);
        idle(2);
        check("co_valid0",  32'(bus.out_valid), 32'h1);
        check("co_digits0", bus.out_digits,     32'h76543210);
        scan(32'h98765432, 8'h7F, SC);
        show(7, seg_of(4'd9), SC);
        bus.out_ready = 1'b1;
        step(1);
        check("co_xfers",   32'(xfer_cnt),        32'd7);
        check("co_cap",     cap_digits,           32'h76543210);
        check("co_valid",   32'(bus.out_valid),   32'h1);
        check("co_digits",  bus.out_digits,       32'h98765432);
        check("co_overrun", 32'(bus.out_overrun), 32'h0);
        idle(2);
        check("co2_xfers", 32'(xfer_cnt),      32'd8);
        check("co2_cap",   cap_digits,         32'h98765432);
        check("co2_valid", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
